// File: rtl/aes_pkg.sv
// AES shared constants, FSM encoding and the forward S-box.
// Imported by the SubBytes stage and, later, key expansion.
package aes_pkg;

  localparam int BYTE   = 8;
  localparam int DWORD  = 32;
  localparam int LENGTH = 128;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [BYTE-1:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward S-box lookup, one byte.
// Table lives in aes_pkg so key expansion can share it.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [BYTE-1:0] in,
  output logic [BYTE-1:0] out
);

  assign out = SBOX[in];

endmodule

// File: rtl/sub_bytes_seq.sv
// Iterative SubBytes: one 32-bit column per cycle, 4 S-boxes.
// Column 0 (bits 127:96) first; result held until consumed.
module sub_bytes_seq
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out
);

  state_t            state;
  logic [1:0]        col;
  logic [LENGTH-1:0] data;
  logic [LENGTH-1:0] data_sub;
  logic [DWORD-1:0]  word;
  logic [DWORD-1:0]  word_sub;
  logic              accept;

  assign in_ready = !rst &&
    ((state == IDLE) ||
     ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out       = data;

  // Select the active column, most significant first.
  always_comb begin
    word = data[127:96];
    unique case (col)
      2'd0: word = data[127:96];
      2'd1: word = data[95:64];
      2'd2: word = data[63:32];
      2'd3: word = data[31:0];
    endcase
  end

  for (genvar i = 0; i < DWORD / BYTE; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in  (word[BYTE*i +: BYTE]),
      .out (word_sub[BYTE*i +: BYTE])
    );
  end

  // Write the substituted column back in place.
  always_comb begin
    data_sub = data;
    unique case (col)
      2'd0: data_sub[127:96] = word_sub;
      2'd1: data_sub[95:64]  = word_sub;
      2'd2: data_sub[63:32]  = word_sub;
      2'd3: data_sub[31:0]   = word_sub;
    endcase
  end

  // FSM, column counter and data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col   <= 2'd0;
      data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            data  <= in;
            col   <= 2'd0;
            state <= BUSY;
          end
        end
        BUSY: begin
          data <= data_sub;
          col  <= col + 2'd1;
          if (col == 2'd3) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (accept) begin
            data  <= in;
            col   <= 2'd0;
            state <= BUSY;
          end else if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          col   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: GF(2^8)-derived reference,
// per-cycle protocol model, scoreboard, directed vectors.
module tb_sub_bytes_seq;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out;

  int n_chk = 0;
  int n_err = 0;
  int n_push = 0;
  int n_deliv = 0;

  logic [7:0]   sb [256];
  logic [127:0] sb_q [$];

  bit           m_occ = 0;
  int           m_age = 0;
  bit           m_zero = 1;
  logic [127:0] m_exp = '0;

  sub_bytes_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v,
                                      input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      b = inv;
      sb[a] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3)
            ^ rotl(b, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = sb[v[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Per-cycle protocol model plus in-order scoreboard.
  always @(negedge clk) begin : cmp
    bit ev, er;
    logic [127:0] front;
    ev = m_occ && (m_age >= 4);
    er = !rst && (!m_occ || (ev && out_ready));
    chk(out_valid === ev, "out_valid",
        128'(out_valid), 128'(ev));
    chk(in_ready === er, "in_ready",
        128'(in_ready), 128'(er));
    if (ev) chk(out === m_exp, "out_data", out, m_exp);
    if (m_zero) chk(out === '0, "out_zero", out, '0);
    if (rst) begin
      sb_q.delete();
      m_occ = 0;
      m_age = 0;
      m_zero = 1;
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk(0, "sb_dup", out, '0);
        end else begin
          front = sb_q.pop_front();
          chk(out === ref_sub(front), "sb_order",
              out, ref_sub(front));
        end
        n_deliv++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(in);
        n_push++;
      end
      if (ev && out_ready) m_occ = 0;
      if (in_valid && er) begin
        m_occ = 1;
        m_age = 0;
        m_exp = ref_sub(in);
        m_zero = 0;
      end else if (m_occ) begin
        m_age++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [127:0] blk,
                           input logic [127:0] want,
                           input string name);
    int n;
    in = blk;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk(n == 4, {name, "_lat"}, 128'(n), 128'd4);
    chk(out === want, name, out, want);
    tick();
  endtask

  localparam logic [127:0] FIPS_IN =
    128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT =
    128'hd42711aee0bf98f1b8b45de51e415230;

  initial begin : main
    logic [127:0] a, b, held;
    logic [127:0] blks [3];
    logic [127:0] outs [3];
    int times [3];
    int got, idx, n, base, sent;
    bit acc;

    build_sbox();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk(in_ready === 1'b1, "ready_after_rst",
        128'(in_ready), 128'd1);

    chk(ref_sub(FIPS_IN) === FIPS_OUT, "model_fips",
        ref_sub(FIPS_IN), FIPS_OUT);
    run_block(FIPS_IN, FIPS_OUT, "fips");
    run_block('0, {16{8'h63}}, "all00");
    run_block('1, {16{8'h16}}, "allff");
    run_block({16{8'h53}}, {16{8'hed}}, "all53");

    a = rand128();
    b = rand128();
    in = a;
    in_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in = b;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    held = out;
    chk(held === ref_sub(a), "bp_val", held, ref_sub(a));
    for (int i = 0; i < 10; i++) begin
      chk(out_valid === 1'b1, "bp_valid",
          128'(out_valid), 128'd1);
      chk(out === held, "bp_stable", out, held);
      chk(in_ready === 1'b0, "bp_ready",
          128'(in_ready), 128'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk(in_ready === 1'b1, "bp_release",
        128'(in_ready), 128'd1);
    tick();
    chk(out_valid === 1'b0, "bp_restart",
        128'(out_valid), 128'd0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk(out === ref_sub(b), "bp_second", out, ref_sub(b));
    tick();

    for (int i = 0; i < 3; i++) blks[i] = rand128();
    idx = 0;
    got = 0;
    in = blks[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 60 && got < 3; c++) begin
      if (out_valid) begin
        outs[got] = out;
        times[got] = c;
        got++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) in = blks[idx];
        else in_valid = 1'b0;
      end
    end
    chk(got == 3, "b2b_count", 128'(got), 128'd3);
    for (int i = 0; i < got; i++)
      chk(outs[i] === ref_sub(blks[i]), "b2b_data",
          outs[i], ref_sub(blks[i]));
    for (int i = 1; i < got; i++)
      chk(times[i] - times[i-1] == 5, "b2b_gap",
          128'(times[i] - times[i-1]), 128'd5);
    tick();

    a = rand128();
    in = a;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk(out_valid === 1'b0, "rst_valid",
        128'(out_valid), 128'd0);
    chk(out === '0, "rst_out", out, '0);
    chk(in_ready === 1'b0, "rst_ready",
        128'(in_ready), 128'd0);
    rst = 1'b0;
    #1;
    chk(in_ready === 1'b1, "rst_release",
        128'(in_ready), 128'd1);
    b = rand128();
    run_block(b, ref_sub(b), "rst_fresh");

    base = n_deliv;
    sent = 0;
    in = rand128();
    for (int c = 0; c < 40000 && (n_deliv - base) < 1000; c++)
    begin
      in_valid = (sent < 1000) && ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      acc = in_valid && in_ready;
      if (acc) sent++;
      tick();
      if (acc) in = rand128();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk(n_deliv - base == 1000, "rand_deliv",
        128'(n_deliv - base), 128'd1000);
    chk(sent == 1000, "rand_sent", 128'(sent), 128'd1000);
    tick();
    chk(sb_q.size() == 0, "sb_empty",
        128'(sb_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
